// File: rtl/sqrt_pkg.sv
// Shared definitions for the sqrt / sq_fixed pair: default Q-format, handshake FSM states,
// and the counter width helper.
package sqrt_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_FBITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/sq_fixed.sv
// Sequential fixed-point squarer: rad = (root*root + rem) >> FBITS, one shift-add step per
// cycle, saturating on overflow and flagging discarded fractional bits.
module sq_fixed
    import sqrt_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FBITS = DEF_FBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] rad,
    output logic             ovf,
    output logic             inexact
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [ACC_W-1:0] FMASK = (ACC_W'(1) << FBITS) - ACC_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   root_q, root_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rad_q, rad_d;
    logic               ovf_q, ovf_d;
    logic               inexact_q, inexact_d;
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            root_q    <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            rad_q     <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rad_q     <= rad_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        root_d    = root_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        rad_d     = rad_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;
        valid_d   = 1'b0;
        p         = acc_q + ACC_W'(rem_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    root_d  = root;
                    rem_d   = rem;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (root_q[cnt_q])
                    acc_d = acc_q + (ACC_W'(root_q) << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT)
                    state_d = ADD;
            end
            ADD: begin
                // p >> FBITS: bits at and above WIDTH+FBITS are the overflow, the WIDTH bits below form rad
                ovf_d     = |p[ACC_W-1:WIDTH+FBITS];
                rad_d     = ovf_d ? '1 : p[WIDTH+FBITS-1:FBITS];
                inexact_d = |(p & FMASK);
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign valid   = valid_q;
    assign rad     = rad_q;
    assign ovf     = ovf_q;
    assign inexact = inexact_q;

endmodule
